truth_table_sweep: RTL and testbench
====================================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter: N_IN, default 2, number of function inputs; legal range 1..4.
REQ-002 Parameter: TT_W, default 2**N_IN, truth-table width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_we  input  1  load strobe for truth table.
REQ-006 cfg_tt  input  TT_W  truth table; bit i = f(input vector i).
REQ-007 x_in  input  N_IN  direct-evaluation input vector.
REQ-008 eval_s  output  1  registered f(x_in).
REQ-009 start  input  1  single-cycle request to sweep all input vectors.
REQ-010 busy  output  1  high while sweep in progress.
REQ-011 out_valid  output  1  sweep row available.
REQ-012 out_ready  input  1  consumer accepts row.
REQ-013 out_vec  output  N_IN  input vector of current row.
REQ-014 out_s  output  1  f(out_vec) of current row.
REQ-015 done  output  1  one-cycle pulse after last row accepted.
REQ-016 ones_cnt  output  N_IN+1  count of rows with out_s=1 in the last completed sweep.

Function
REQ-017 Truth-table register SHALL load cfg_tt on cfg_we=1 only in IDLE; cfg_we SHALL be ignored in SWEEP and DONE.
REQ-018 eval_s SHALL equal tt[x_in] one cycle after x_in is sampled, in every state, using the current table.
REQ-019 FSM states SHALL be IDLE, SWEEP, DONE.
REQ-020 IDLE -> SWEEP on start=1; idx cleared to 0 and the running count cleared on the same edge.
REQ-021 In SWEEP: out_valid=1, out_vec=idx, out_s=tt[idx], busy=1.
REQ-022 A row SHALL be transferred only on out_valid=1 and out_ready=1; idx increments by 1 and the running count adds out_s on that edge.
REQ-023 With out_ready=0, out_vec and out_s SHALL hold stable; no row may be skipped or repeated.
REQ-024 Transfer at idx=TT_W-1 SHALL move to DONE; idx SHALL NOT wrap within a sweep.
REQ-025 DONE SHALL last exactly one cycle: done=1, busy=0, out_valid=0, ones_cnt updated from the final count; the next state is IDLE.
REQ-026 ones_cnt SHALL hold its value until the next DONE; its maximum is TT_W (N_IN+1 bits, no overflow).
REQ-027 start during SWEEP or DONE SHALL be ignored (not queued).
REQ-028 With out_ready tied to 1, a sweep SHALL occupy TT_W SWEEP cycles, then 1 DONE cycle.
REQ-029 Outside SWEEP: out_valid=0, out_vec=0, out_s=0.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, idx=0, running count=0, tt=0, eval_s=0, ones_cnt=0, done=0, busy=0, out_valid=0.
REQ-031 Reset asserted mid-sweep SHALL abort it; no done pulse is produced and ones_cnt is cleared.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, SWEEP, DONE) and the N_IN legal-range constants.
REQ-033 One sub-module, tt_lookup (combinational TT_W:1 mux indexed by an N_IN vector), SHALL be instantiated twice, for eval_s and out_s.

Verification
REQ-034 N_IN=2, cfg_tt=4'b0100 (f = ~x & y), x_in swept 00,01,10,11 -> eval_s = 0,1,0,0, each one cycle later.
REQ-035 N_IN=2, cfg_tt=4'b0110, out_ready=1, start -> rows (00,0),(01,1),(10,1),(11,0) on 4 consecutive cycles; done on cycle 5; ones_cnt=2.
REQ-036 N_IN=3, cfg_tt=8'hFF, out_ready toggling 1,0 -> 8 rows, each stable while stalled, none repeated; ones_cnt=8.
REQ-037 Mid-sweep start pulse and cfg_we=1 with cfg_tt=0 -> sweep unaffected; remaining rows use the original table.
REQ-038 rst_n=0 at row 2 of a sweep -> next cycle IDLE, out_valid=0, ones_cnt=0, no done pulse.
REQ-039 N_IN=4, cfg_tt=16'h8001, out_ready=1 -> 16 rows, out_s=1 only at vectors 0000 and 1111; ones_cnt=2.

Source files
------------

// File: rtl/truth_table_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package truth_table_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 4;

endpackage

// File: rtl/truth_table_sweep_tt_lookup.sv
// Combinational truth-table read: returns tt[sel].
module tt_lookup #(
  parameter  int N_IN = 2,
  localparam int TT_W = 2**N_IN
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] sel,
  output logic            f
);

  assign f = tt[sel];

endmodule

// File: rtl/truth_table_sweep.sv
// Programmable N-input boolean function with direct evaluation and a
// handshaked sweep that emits every row of the table and counts the ones.
//
// state    | meaning
// ST_IDLE  | table writable, waiting for start
// ST_SWEEP | presenting row idx, advancing on out_ready
// ST_DONE  | one-cycle done pulse, ones_cnt just updated
module truth_table_sweep
  import truth_table_sweep_pkg::*;
#(
  parameter  int N_IN = 2,
  localparam int TT_W = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [TT_W-1:0]   cfg_tt,
  input  logic [N_IN-1:0]   x_in,
  output logic              eval_s,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN-1:0]   out_vec,
  output logic              out_s,
  output logic              done,
  output logic [N_IN:0]     ones_cnt
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("truth_table_sweep: N_IN out of legal range");
  end

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            eval_s_q, eval_s_d;
  logic [N_IN:0]   ones_q, ones_d;

  logic eval_f;
  logic row_s;

  tt_lookup #(.N_IN(N_IN)) u_eval_lookup (
    .tt  (tt_q),
    .sel (x_in),
    .f   (eval_f)
  );

  tt_lookup #(.N_IN(N_IN)) u_row_lookup (
    .tt  (tt_q),
    .sel (idx_q),
    .f   (row_s)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tt_d     = tt_q;
    ones_d   = ones_q;
    eval_s_d = eval_f;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          tt_d = cfg_tt;
        end
        if (start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (out_ready) begin
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + (N_IN+1)'(row_s);
          // Final row: publish the count now so it is visible during DONE
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = '0;
            ones_d  = cnt_q + (N_IN+1)'(row_s);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tt_q     <= '0;
      eval_s_q <= 1'b0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tt_q     <= tt_d;
      eval_s_q <= eval_s_d;
      ones_q   <= ones_d;
    end
  end

  assign eval_s    = eval_s_q;
  assign busy      = (state_q == ST_SWEEP);
  assign out_valid = (state_q == ST_SWEEP);
  assign out_vec   = (state_q == ST_SWEEP) ? idx_q : '0;
  assign out_s     = (state_q == ST_SWEEP) & row_s;
  assign done      = (state_q == ST_DONE);
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: directed vectors on N_IN=2/3/4 instances plus
// a randomized run of the N_IN=4 instance against a row-queue reference model.
module tb_truth_table_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_tt;
  logic [3:0]  x_in;
  logic        out_ready;
  logic        we2, we3, we4, st2, st3, st4;

  logic       e2, b2, v2, s2, d2;
  logic [1:0] vec2;
  logic [2:0] ones2;
  logic       e3, b3, v3, s3, d3;
  logic [2:0] vec3;
  logic [3:0] ones3;
  logic       e4, b4, v4, s4, d4;
  logic [3:0] vec4;
  logic [4:0] ones4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] x;
    logic       exp;
  } eval_vec_t;

  typedef struct {
    int vec;
    bit s;
  } row_t;

  row_t        rq[$];
  logic [15:0] m_tt;
  bit          m_eval, m_done, nxt_eval;
  int          m_ones;

  always #5 clk = ~clk;

  truth_table_sweep #(.N_IN(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(we2), .cfg_tt(cfg_tt[3:0]), .x_in(x_in[1:0]),
    .eval_s(e2), .start(st2), .busy(b2), .out_valid(v2), .out_ready(out_ready),
    .out_vec(vec2), .out_s(s2), .done(d2), .ones_cnt(ones2)
  );

  truth_table_sweep #(.N_IN(3)) u_n3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(we3), .cfg_tt(cfg_tt[7:0]), .x_in(x_in[2:0]),
    .eval_s(e3), .start(st3), .busy(b3), .out_valid(v3), .out_ready(out_ready),
    .out_vec(vec3), .out_s(s3), .done(d3), .ones_cnt(ones3)
  );

  truth_table_sweep #(.N_IN(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .cfg_we(we4), .cfg_tt(cfg_tt), .x_in(x_in),
    .eval_s(e4), .start(st4), .busy(b4), .out_valid(v4), .out_ready(out_ready),
    .out_vec(vec4), .out_s(s4), .done(d4), .ones_cnt(ones4)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input logic [15:0] v);
    cfg_tt = v;
    case (k)
      2:       we2 = 1'b1;
      3:       we3 = 1'b1;
      default: we4 = 1'b1;
    endcase
    tick();
    we2 = 1'b0;
    we3 = 1'b0;
    we4 = 1'b0;
  endtask

  initial begin
    eval_vec_t evt[4];
    row_t      rows2[4];
    int        e;
    int        cyc;

    rst_n = 1'b0; cfg_tt = '0; x_in = '0; out_ready = 1'b0;
    we2 = 0; we3 = 0; we4 = 0; st2 = 0; st3 = 0; st4 = 0;
    tick();
    tick();

    // Reset state of all three instances
    chk("rst_eval", 32'({e2, e3, e4}), 0);
    chk("rst_busy", 32'({b2, b3, b4}), 0);
    chk("rst_valid", 32'({v2, v3, v4}), 0);
    chk("rst_done", 32'({d2, d3, d4}), 0);
    chk("rst_out_s", 32'({s2, s3, s4}), 0);
    chk("rst_vec", 32'({vec2, vec3, vec4}), 0);
    chk("rst_ones", 32'({ones2, ones3, ones4}), 0);
    rst_n = 1'b1;
    tick();

    // f = ~x & y with x on bit 0 and y on bit 1: (x,y)=00,01,10,11
    evt[0] = '{4'd0, 1'b0};
    evt[1] = '{4'd2, 1'b1};
    evt[2] = '{4'd1, 1'b0};
    evt[3] = '{4'd3, 1'b0};
    load(2, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      x_in = evt[i].x;
      tick();
      chk($sformatf("eval2_x%0d", evt[i].x), 32'(e2), 32'(evt[i].exp));
    end

    // Back-to-back sweep on table 0110 with out_ready held high
    rows2[0] = '{0, 1'b0};
    rows2[1] = '{1, 1'b1};
    rows2[2] = '{2, 1'b1};
    rows2[3] = '{3, 1'b0};
    load(2, 16'h0006);
    out_ready = 1'b1;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("sw2_valid_r%0d", r), 32'(v2), 1);
      chk($sformatf("sw2_busy_r%0d", r), 32'(b2), 1);
      chk($sformatf("sw2_vec_r%0d", r), 32'(vec2), rows2[r].vec);
      chk($sformatf("sw2_s_r%0d", r), 32'(s2), 32'(rows2[r].s));
      chk($sformatf("sw2_done_r%0d", r), 32'(d2), 0);
      tick();
    end
    chk("sw2_done_pulse", 32'(d2), 1);
    chk("sw2_done_valid", 32'(v2), 0);
    chk("sw2_done_busy", 32'(b2), 0);
    chk("sw2_ones", 32'(ones2), 2);
    tick();
    chk("sw2_done_one_cycle", 32'(d2), 0);
    chk("sw2_ones_hold", 32'(ones2), 2);

    // N_IN=3, all-ones table, consumer stalls every other cycle
    load(3, 16'h00FF);
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 8 && cyc < 40) begin
      chk("sw3_valid", 32'(v3), 1);
      chk("sw3_vec", 32'(vec3), e);
      chk("sw3_s", 32'(s3), 1);
      chk("sw3_no_done", 32'(d3), 0);
      out_ready = (cyc % 2 == 0);
      tick();
      if (out_ready) e++;
      cyc++;
    end
    chk("sw3_rows", e, 8);
    chk("sw3_done", 32'(d3), 1);
    chk("sw3_ones", 32'(ones3), 8);
    out_ready = 1'b1;
    tick();

    // Start and table write during a sweep are both ignored
    load(2, 16'h0006);
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk("mid_vec0", 32'(vec2), 0);
    tick();
    chk("mid_vec1", 32'(vec2), 1);
    st2 = 1'b1; we2 = 1'b1; cfg_tt = 16'h0000;
    tick();
    st2 = 1'b0; we2 = 1'b0;
    chk("mid_vec2", 32'(vec2), 2);
    chk("mid_s2", 32'(s2), 1);
    tick();
    chk("mid_vec3", 32'(vec2), 3);
    chk("mid_s3", 32'(s2), 0);
    tick();
    chk("mid_done", 32'(d2), 1);
    chk("mid_ones", 32'(ones2), 2);
    x_in = 4'd1;
    tick();
    chk("mid_no_requeue", 32'(v2), 0);
    tick();
    chk("mid_table_kept", 32'(e2), 1);

    // Reset at row 2 aborts the sweep
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    tick();
    tick();
    chk("abort_at_row2", 32'(vec2), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(v2), 0);
    chk("abort_busy", 32'(b2), 0);
    chk("abort_ones", 32'(ones2), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'({d2, v2}), 0);
      tick();
    end

    // N_IN=4, ones only at vectors 0000 and 1111
    load(4, 16'h8001);
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sw4_vec_%0d", i), 32'(vec4), i);
      chk($sformatf("sw4_s_%0d", i), 32'(s4), 32'(i == 0 || i == 15));
      tick();
    end
    chk("sw4_done", 32'(d4), 1);
    chk("sw4_ones", 32'(ones4), 2);

    // Randomized run against the row-queue model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rq.delete();
    m_tt = '0; m_eval = 0; m_done = 0; m_ones = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(v4), 32'(rq.size() > 0));
      chk("rnd_busy", 32'(b4), 32'(rq.size() > 0));
      if (rq.size() > 0) begin
        chk("rnd_vec", 32'(vec4), rq[0].vec);
        chk("rnd_s", 32'(s4), 32'(rq[0].s));
      end else begin
        chk("rnd_vec_idle", 32'({vec4, s4}), 0);
      end
      chk("rnd_done", 32'(d4), 32'(m_done));
      chk("rnd_ones", 32'(ones4), m_ones);
      chk("rnd_eval", 32'(e4), 32'(m_eval));

      rst_n     = ($urandom % 64) != 0;
      st4       = ($urandom % 12) == 0;
      we4       = ($urandom % 6) == 0;
      cfg_tt    = 16'($urandom);
      x_in      = 4'($urandom);
      out_ready = ($urandom % 3) != 0;

      if (!rst_n) begin
        rq.delete();
        m_tt = '0; m_eval = 0; m_done = 0; m_ones = 0;
      end else begin
        nxt_eval = m_tt[x_in];
        if (rq.size() > 0) begin
          if (out_ready) begin
            void'(rq.pop_front());
            if (rq.size() == 0) begin
              m_done = 1;
              m_ones = $countones(m_tt);
            end
          end
        end else if (m_done) begin
          m_done = 0;
        end else begin
          if (we4) m_tt = cfg_tt;
          if (st4) begin
            for (int i = 0; i < 16; i++) rq.push_back('{i, m_tt[i]});
          end
        end
        m_eval = nxt_eval;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
